// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with synchronous load and one-shot mode.
// It provides a combinational terminal count for cascading, plus a registered wrap pulse and a saturating wrap tally.
module mod_n_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 9,
    parameter int WRAP_W  = 8
) (
    input  logic              clkIn,
    input  logic              rstnIn,
    input  logic              enIn,
    input  logic              upIn,
    input  logic              loadIn,
    input  logic [WIDTH-1:0]  loadDat,
    input  logic              oneShotIn,
    output logic [WIDTH-1:0]  Dat,
    output logic              tcOut,
    output logic              wrapOut,
    output logic              doneOut,
    output logic              loadErr,
    output logic [WRAP_W-1:0] wrapCnt
);

    localparam logic [WIDTH-1:0]  MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);
    localparam logic [WIDTH:0]    MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    generate
        if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
            $error("mod_n_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] wrap_val;
    logic             at_term;
    logic             load_ok;

    // The load range check is one bit wider so that MODULUS == 2^WIDTH compares correctly.
    always_comb begin
        term_val = upIn ? MAX_VAL : '0;
        wrap_val = upIn ? '0 : MAX_VAL;
        step_val = upIn ? (Dat + ONE) : (Dat - ONE);
        at_term  = (Dat == term_val);
        load_ok  = ({1'b0, loadDat} < MOD_EXT);
    end

    assign tcOut = enIn & at_term & ~(oneShotIn & doneOut);

    always_ff @(posedge clkIn) begin
        if (!rstnIn) begin
            Dat     <= '0;
            wrapOut <= 1'b0;
            doneOut <= 1'b0;
            loadErr <= 1'b0;
            wrapCnt <= '0;
        end else if (loadIn) begin
            Dat     <= load_ok ? loadDat : '0;
            loadErr <= ~load_ok;
            wrapOut <= 1'b0;
            doneOut <= 1'b0;
            wrapCnt <= '0;
        end else begin
            wrapOut <= 1'b0;
            loadErr <= 1'b0;
            // A finished one-shot run freezes everything until a load or reset.
            if (enIn && !doneOut) begin
                if (!at_term) begin
                    Dat <= step_val;
                end else if (!oneShotIn) begin
                    Dat     <= wrap_val;
                    wrapOut <= 1'b1;
                    if (wrapCnt != '1) begin
                        wrapCnt <= wrapCnt + WRAP_ONE;
                    end
                end else begin
                    doneOut <= 1'b1;
                end
            end
        end
    end

endmodule
